// File: rtl/ic_hc_block_sequencer.sv
// ic_hc_block_sequencer
// Drains one 8x8 block at a time from the EOB FIFO (ff1) and the row FIFO (ff0)
// and turns it into a DC / AC(run,value) / ZRL / EOB symbol stream for the
// Huffman table lookup stage. The output is a single registered slot: the
// scanner loads it when it is empty or being accepted this cycle, so with
// out_ready held high one coefficient is examined per clock.
module ic_hc_block_sequencer #(
   parameter int COEF_W    = 13,
   parameter int ROW_COEFS = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ff1_empty,
   input  logic [5:0]                  ff1_q,
   output logic                        ff1_rdreq,
   input  logic                        ff0_empty,
   input  logic [COEF_W*ROW_COEFS-1:0] ff0_q,
   output logic                        ff0_rdreq,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [1:0]                  out_type,
   output logic [3:0]                  out_run,
   output logic [COEF_W-1:0]           out_value,
   output logic                        out_last,
   output logic                        busy
);

   localparam logic [1:0] T_DC  = 2'd0;
   localparam logic [1:0] T_AC  = 2'd1;
   localparam logic [1:0] T_ZRL = 2'd2;
   localparam logic [1:0] T_EOB = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EOB_REQ,
      S_EOB_LAT,
      S_ROW_REQ,
      S_ROW_LAT,
      S_SCAN,
      S_EMIT_EOB
   } state_t;

   typedef struct packed {
      logic [1:0]        typ;
      logic [3:0]        run;
      logic [COEF_W-1:0] value;
      logic              last;
   } sym_t;

   state_t                           state;
   logic [ROW_COEFS-1:0][COEF_W-1:0] row_r;
   logic [5:0]                       eob_r;
   logic [5:0]                       run_r;
   logic [2:0]                       row_cnt;
   logic [2:0]                       lane;
   sym_t                             sym_r;
   logic                             valid_r;

   // Scan decode for the coefficient currently under examination.
   logic [5:0]        idx;
   logic [COEF_W-1:0] coef;
   logic              coef_nz;
   logic              at_eob;
   logic              slot_free;
   logic              need_zrl;
   logic              scan_emit;
   logic              scan_zrl;
   logic              scan_zero;
   logic              scan_adv;

   assign idx       = {row_cnt, lane};
   assign coef      = row_r[lane];
   assign coef_nz   = |coef;
   assign at_eob    = (idx == eob_r);
   assign slot_free = !valid_r || out_ready;
   assign need_zrl  = (idx != 6'd0) && (run_r >= 6'd16);

   // DC always emits; nonzero AC emits once the pending run fits in 4 bits.
   assign scan_emit = (state == S_SCAN) && ((idx == 6'd0) || coef_nz) && slot_free && !need_zrl;
   assign scan_zrl  = (state == S_SCAN) && coef_nz && slot_free && need_zrl;
   // Zero AC coefficients never touch the output slot, so they never stall.
   assign scan_zero = (state == S_SCAN) && (idx != 6'd0) && !coef_nz;
   assign scan_adv  = scan_emit || scan_zero;

   // Block sequencing FSM with registered FIFO requests and output slot.
   // Read requests are raised on the transition into the request state using
   // the empty flag seen that cycle: this block is the only reader, so a
   // non-empty FIFO stays non-empty until the pulse lands, and each fetch
   // costs exactly two cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         ff0_rdreq <= 1'b0;
         ff1_rdreq <= 1'b0;
         valid_r   <= 1'b0;
         sym_r     <= '0;
         busy      <= 1'b0;
         run_r     <= 6'd0;
         row_cnt   <= 3'd0;
         lane      <= 3'd0;
         eob_r     <= 6'd0;
      end else begin
         ff0_rdreq <= 1'b0;
         ff1_rdreq <= 1'b0;
         // Retire an accepted symbol; a load below overrides this.
         if (valid_r && out_ready)
            valid_r <= 1'b0;

         case (state)
            S_IDLE: begin
               if (!ff1_empty) begin
                  ff1_rdreq <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_EOB_REQ;
               end
            end

            S_EOB_REQ: state <= S_EOB_LAT;

            S_EOB_LAT: begin
               eob_r     <= ff1_q;
               row_cnt   <= 3'd0;
               run_r     <= 6'd0;
               ff0_rdreq <= !ff0_empty;
               state     <= S_ROW_REQ;
            end

            S_ROW_REQ: begin
               if (ff0_rdreq)
                  state <= S_ROW_LAT;
               else
                  ff0_rdreq <= !ff0_empty;
            end

            S_ROW_LAT: begin
               row_r <= ff0_q;
               lane  <= 3'd0;
               state <= S_SCAN;
            end

            S_SCAN: begin
               if (scan_zrl) begin
                  valid_r     <= 1'b1;
                  sym_r.typ   <= T_ZRL;
                  sym_r.run   <= 4'd0;
                  sym_r.value <= '0;
                  sym_r.last  <= 1'b0;
                  run_r       <= run_r - 6'd16;
               end
               if (scan_emit) begin
                  valid_r     <= 1'b1;
                  sym_r.typ   <= (idx == 6'd0) ? T_DC : T_AC;
                  sym_r.run   <= (idx == 6'd0) ? 4'd0 : run_r[3:0];
                  sym_r.value <= coef;
                  sym_r.last  <= at_eob && (eob_r == 6'd63);
                  run_r       <= 6'd0;
               end
               if (scan_zero)
                  run_r <= run_r + 6'd1;
               if (scan_adv) begin
                  if (at_eob) begin
                     // A full block ends on its own last AC; anything else
                     // is closed by an explicit EOB symbol.
                     if (scan_emit && (eob_r == 6'd63)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state <= S_EMIT_EOB;
                     end
                  end else if (lane == 3'd7) begin
                     row_cnt   <= row_cnt + 3'd1;
                     ff0_rdreq <= !ff0_empty;
                     state     <= S_ROW_REQ;
                  end else begin
                     lane <= lane + 3'd1;
                  end
               end
            end

            S_EMIT_EOB: begin
               // EOB is the only symbol of that type, so its presence in the
               // slot marks that it has been loaded and waits for acceptance.
               if (valid_r && (sym_r.typ == T_EOB)) begin
                  if (out_ready) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else if (slot_free) begin
                  valid_r     <= 1'b1;
                  sym_r.typ   <= T_EOB;
                  sym_r.run   <= 4'd0;
                  sym_r.value <= '0;
                  sym_r.last  <= 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = valid_r;
   assign out_type  = sym_r.typ;
   assign out_run   = sym_r.run;
   assign out_value = sym_r.value;
   assign out_last  = sym_r.last;

endmodule

// File: doc/ic_hc_block_sequencer.md
Name: ic_hc_block_sequencer

Overview:
- Drains the Huffman-coding input-preparation FIFOs one 8x8 block at a time. Sources are the row FIFO (ff0, 104-bit rows of eight 13-bit zig-zag coefficients) and the EOB FIFO (ff1, 6-bit index of the last nonzero coefficient).
- Converts each block into a symbol stream (DC, AC run/value, ZRL, EOB) for the Huffman encoder, over a valid/ready handshake.
- Sits between ic_hc_input_preparation and the Huffman table lookup stage.

Parameters:
- COEF_W, 13, coefficient width in bits.
- ROW_COEFS, 8, coefficients per FIFO row. Fixed: row width = COEF_W*ROW_COEFS = 104.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ff1_empty  in  1  EOB FIFO empty.
- ff1_q  in  6  EOB FIFO data. Non-showahead: valid the cycle after rdreq.
- ff1_rdreq  out  1  EOB FIFO read request.
- ff0_empty  in  1  row FIFO empty.
- ff0_q  in  104  row FIFO data. Non-showahead. Lane k = bits[13k+12:13k], coefficient index = row*8+k.
- ff0_rdreq  out  1  row FIFO read request.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accepts symbol.
- out_type  out  2  0=DC, 1=AC, 2=ZRL, 3=EOB.
- out_run  out  4  zero run preceding an AC value. 0 for DC/ZRL/EOB.
- out_value  out  13  coefficient value. 0 for ZRL/EOB.
- out_last  out  1  final symbol of block.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State goes to IDLE.
  - ff0_rdreq, ff1_rdreq, out_valid, out_last, busy = 0; out_type/run/value = 0.
  - Run counter, row counter, lane counter and EOB register cleared.
  - Reset mid-block abandons the block; no further symbols for it. FIFO contents are untouched (the FIFO sclr is the owner's concern).
- All outputs are registered. rdreq pulses are exactly one cycle wide.
- States: IDLE, EOB_REQ, EOB_LAT, ROW_REQ, ROW_LAT, SCAN, EMIT_EOB.
- IDLE -> EOB_REQ when ff1_empty=0. EOB_REQ asserts ff1_rdreq for one cycle.
- EOB_LAT: latch ff1_q into eob_r, clear row=0 and run=0, then go to ROW_REQ.
- ROW_REQ:
  - If ff0_empty=1, wait with ff0_rdreq=0. No timeout.
  - Else pulse ff0_rdreq and go to ROW_LAT.
- ROW_LAT: latch ff0_q into the row register, lane=0, then go to SCAN.
- SCAN examines one coefficient per cycle, idx = {row[2:0], lane[2:0]}:
  - idx=0: emit DC(value=coef, run=0).
  - idx>0, coef=0: run+1, no emission, advance next cycle.
  - idx>0, coef!=0, run>=16: emit ZRL, run-=16, same lane re-examined after acceptance.
  - idx>0, coef!=0, run<16: emit AC(run, coef), run=0.
- Advance happens only when the emitted symbol is accepted (out_valid & out_ready). Zero coefficients advance unconditionally.
- Advance order:
  - If idx==eob_r and eob_r==63, the symbol carries out_last=1 and the state goes to IDLE.
  - If idx==eob_r and eob_r<63, go to EMIT_EOB. Remaining lanes are ignored.
  - Else if lane==7, row+1 and go to ROW_REQ.
  - Else lane+1.
- EMIT_EOB: emit EOB with out_last=1; on acceptance go to IDLE.
- Handshake:
  - out_valid rises only with a stable payload.
  - The payload and out_valid are held unchanged until out_ready=1 at a clock edge.
  - No combinational path from out_ready to out_valid.
- Row count consumed per block = eob_r[5:3]+1. This matches the number of rows the producer writes. The block never reads beyond that count.
- Throughput: 1 coefficient per cycle in SCAN with out_ready=1. Overhead is 2 cycles per row fetch plus 2 cycles per block start.
- All-zero block (eob_r=0, single row): DC value 0, then EOB.
- The run counter is 6 bits wide; multiple consecutive ZRLs are permitted.

Test Plan:
- All-zero block (ff1_q=0, one zero row), out_ready=1 -> DC(value 0, last 0), then EOB(last 1); exactly one ff0_rdreq and one ff1_rdreq; back to IDLE.
- eob=63, 8 rows with coef[i]=i+1 -> 64 symbols: DC 1, then AC run 0 values 2..64; last=1 on the value-64 AC; no EOB symbol; 8 ff0_rdreq pulses.
- eob=21, coef0=5, coef21=0x1FFD, all others 0 -> DC 5, ZRL, AC(run 4, value 0x1FFD), EOB(last 1); 3 rows read.
- Backpressure: out_ready low for 3 cycles while AC(run 0, value 7) is presented -> out_valid and payload stable for all 3 cycles; accepted once; no symbol lost or duplicated.
- Starvation: ff0_empty=1 after the first row of an eob=40 block -> ff0_rdreq stays 0, out_valid stays 0, busy=1; on refill the block resumes with the correct run count.
- Reset asserted in SCAN mid-block -> next cycle out_valid=0, busy=0, rdreqs=0; a following block (eob=0) yields DC, EOB correctly.
